instruction_memory: RTL and testbench

Word-addressed instruction ROM/RAM for the single-cycle MIPS datapath. It returns the 32-bit instruction at the word index on Address combinationally, so the fetch stage sees it in the same cycle. A synchronous load port allows the program to be overwritten. Asynchronous reset restores the built-in default program.

---
 rtl/instruction_memory.sv | 72 +++++++
 tb/tb_instruction_memory.sv | 139 +++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// Word-addressed instruction store for the single-cycle MIPS fetch path.
// Combinational read, synchronous load port, async reset to the built-in program.

module instruction_memory_word #(
  parameter logic [31:0] INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= INIT;
    else if (we) q <= wdata;
  end
endmodule

module instruction_memory #(
  parameter int DEPTH      = 128,
  parameter int INDEX_BITS = 7
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  output logic [31:0] Instruction,
  input  logic        WriteEnable,
  input  logic [31:0] WriteAddress,
  input  logic [31:0] WriteData
);

  function automatic logic [31:0] default_word(input int idx);
    case (idx)
      0:       return 32'h2008_0005; // addi $t0,$0,5
      1:       return 32'h2009_0003; // addi $t1,$0,3
      2:       return 32'h0109_5020; // add
      3:       return 32'h0109_5822; // sub
      4:       return 32'h0109_6024; // and
      5:       return 32'h0109_6825; // or
      6:       return 32'h0109_702A; // slt
      7:       return 32'hAC0A_0000; // sw
      8:       return 32'h8C0F_0000; // lw
      9:       return 32'h0800_0000; // j 0
      default: return 32'h0000_0000;
    endcase
  endfunction

  logic [DEPTH-1:0][31:0] words;
  logic                   rd_ok, wr_ok;
  logic [INDEX_BITS-1:0]  rd_idx, wr_idx;

  // Full 32-bit range checks: upper address bits never alias onto low words.
  assign rd_ok  = Address      < 32'(DEPTH);
  assign wr_ok  = WriteAddress < 32'(DEPTH);
  assign rd_idx = Address[INDEX_BITS-1:0];
  assign wr_idx = WriteAddress[INDEX_BITS-1:0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    instruction_memory_word #(
      .INIT (default_word(g))
    ) u_word (
      .clk   (Clk),
      .rst   (Rst),
      .we    (WriteEnable && wr_ok && (wr_idx == INDEX_BITS'(g))),
      .wdata (WriteData),
      .q     (words[g])
    );
  end

  assign Instruction = rd_ok ? words[rd_idx] : 32'h0000_0000;

endmodule

// File: tb/tb_instruction_memory.sv
// Randomized and directed check of instruction_memory against an array model.

module tb_instruction_memory;
  localparam int DEPTH = 128;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Address, Instruction, WriteAddress, WriteData;
  logic        WriteEnable;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] prog  [10] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'h01095822,
                              32'h01096024, 32'h01096825, 32'h0109702A, 32'hAC0A0000,
                              32'h8C0F0000, 32'h08000000};

  instruction_memory #(.DEPTH(DEPTH), .INDEX_BITS(7)) dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .Instruction(Instruction),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = (i < 10) ? prog[i] : 32'h0;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return (a < DEPTH) ? model[a] : 32'h0;
  endfunction

  task automatic model_edge();
    if (!Rst && WriteEnable && WriteAddress < DEPTH) model[WriteAddress] = WriteData;
  endtask

  // Walk every word with the write port idle.
  task automatic sweep(input string tag);
    WriteEnable = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      Address = i;
      #1 chk(tag, Instruction, model_rd(Address));
    end
  endtask

  initial begin
    Rst = 1'b1; WriteEnable = 1'b0; Address = 0; WriteAddress = 0; WriteData = 0;
    model_reset();
    #12 Rst = 1'b0;

    // Default program, combinational read
    for (int i = 0; i <= 10; i++) begin
      Address = i;
      #10 chk($sformatf("default[%0d]", i), Instruction, (i < 10) ? prog[i] : 32'h0);
    end

    // Out of range reads never wrap
    Address = 128;          #1 chk("oor128", Instruction, 32'h0);
    Address = 32'hFFFFFFFF; #1 chk("oorFFFF", Instruction, 32'h0);
    Address = 32'h80;       #1 chk("oor80", Instruction, 32'h0);

    // Read-during-write at word 3
    @(negedge Clk);
    WriteEnable = 1'b1; WriteAddress = 3; WriteData = 32'hDEADBEEF; Address = 3;
    #1 chk("rdw_old", Instruction, 32'h01095822);
    @(posedge Clk); model_edge();
    #1 chk("rdw_new", Instruction, 32'hDEADBEEF);
    @(negedge Clk); WriteEnable = 1'b0;
    sweep("after_w3");

    // Out of range write is dropped
    @(negedge Clk);
    WriteEnable = 1'b1; WriteAddress = 200; WriteData = 32'h12345678;
    @(posedge Clk); model_edge();
    #1 Address = 72;
    #1 chk("oor_write72", Instruction, 32'h0);
    @(negedge Clk); WriteEnable = 1'b0;
    sweep("after_oorw");

    // Async reset between edges, write ignored while held
    @(negedge Clk);
    #2 Rst = 1'b1; Address = 3; model_reset();
    #1 chk("rst_async_w3", Instruction, 32'h01095822);
    WriteEnable = 1'b1; WriteAddress = 5; WriteData = 32'hCAFEF00D;
    @(posedge Clk); model_edge();
    #1 Address = 5;
    #1 chk("rst_blocks_wr", Instruction, 32'h01096825);
    @(negedge Clk); WriteEnable = 1'b0; Rst = 1'b0;
    sweep("after_rst");

    // Idle write port across several edges
    @(negedge Clk);
    WriteEnable = 1'b0; WriteAddress = 2; WriteData = 32'h55AA55AA;
    repeat (4) @(posedge Clk);
    #1 Address = 2;
    #1 chk("we0_hold", Instruction, 32'h01095020);
    sweep("after_we0");

    // Random traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      WriteEnable  = ($urandom_range(0, 3) != 0);
      WriteAddress = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, DEPTH - 1);
      WriteData    = $urandom();
      Address      = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 300) : WriteAddress;
      if ($urandom_range(0, 49) == 0) begin
        Rst = 1'b1; model_reset();
      end
      #1 chk("rnd_pre", Instruction, model_rd(Address));
      @(posedge Clk); model_edge();
      #1 chk("rnd_post", Instruction, model_rd(Address));
      Rst = 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        Address = $urandom_range(0, DEPTH + 20);
        #1 chk("rnd_any", Instruction, model_rd(Address));
      end
    end
    @(negedge Clk);
    sweep("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
